// File: rtl/btle_tx_framer.sv
// BLE 1M uncoded TX framer: preamble, access address, PDU from octet RAM, CRC24; whitening under BTLE_TX_WHITENING_EN.
// Latency: first preamble bit is valid the cycle after tx_start is accepted; tx_end pulses the cycle after the last bit.
// Backpressure: bits, CRC, whitening and RAM fetches advance only on bit_valid && bit_ready; bit_out holds otherwise.
module btle_tx_framer #(
   parameter int LEN_UNIQUE_BIT_SEQUENCE  = 32,
   parameter int CHANNEL_NUMBER_BIT_WIDTH = 6,
   parameter int CRC_STATE_BIT_WIDTH      = 24
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [LEN_UNIQUE_BIT_SEQUENCE-1:0]  unique_bit_sequence,
   input  logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] channel_number,
   input  logic [CRC_STATE_BIT_WIDTH-1:0]      crc_state_init_bit,
   input  logic [6:0]                          payload_length,
   input  logic                                tx_start,
   output logic [5:0]                          pdu_octet_mem_addr,
   input  logic [7:0]                          pdu_octet_mem_data,
   output logic                                bit_out,
   output logic                                bit_valid,
   input  logic                                bit_ready,
   output logic                                tx_busy,
   output logic                                tx_end
);
   localparam logic [CRC_STATE_BIT_WIDTH-1:0] CRC_POLY = CRC_STATE_BIT_WIDTH'(24'h00065B);

   typedef enum logic [2:0] {S_IDLE, S_PRE, S_ACC, S_PDU, S_CRC} state_t;

   state_t                               state_q, state_d;
   logic [8:0]                           cnt_q;
   logic [LEN_UNIQUE_BIT_SEQUENCE-1:0]   aa_q;
   logic [CRC_STATE_BIT_WIDTH-1:0]       crc_q;
   logic [5:0]                           len_q, len_sat, addr_q, oct_last;
   logic [7:0]                           oct_q, pre_byte;
   logic [8:0]                           pdu_last;
   logic                                 tx_end_q, start, hs, last_bit, raw_bit, wht_en, wht_bit;

   assign start    = (state_q == S_IDLE) && tx_start;
   assign hs       = bit_valid && bit_ready;
   assign len_sat  = (payload_length > 7'd62) ? 6'd62 : payload_length[5:0];
   assign oct_last = len_q + 6'd1;
   assign pdu_last = {oct_last, 3'b111};
   assign pre_byte = aa_q[0] ? 8'h55 : 8'hAA;

   assign pdu_octet_mem_addr = addr_q;
   assign tx_end             = tx_end_q;

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      last_bit = 1'b0;
      case (state_q)
         S_IDLE: if (tx_start) state_d = S_PRE;
         S_PRE: begin
            last_bit = (cnt_q == 9'd7);
            if (hs && last_bit) state_d = S_ACC;
         end
         S_ACC: begin
            last_bit = (cnt_q == 9'd31);
            if (hs && last_bit) state_d = S_PDU;
         end
         S_PDU: begin
            last_bit = (cnt_q == pdu_last);
            if (hs && last_bit) state_d = S_CRC;
         end
         S_CRC: begin
            last_bit = (cnt_q == 9'd23);
            if (hs && last_bit) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      bit_valid = (state_q != S_IDLE);
      tx_busy   = (state_q != S_IDLE);
      raw_bit   = 1'b0;
      wht_en    = 1'b0;
      case (state_q)
         S_PRE: raw_bit = pre_byte[cnt_q[2:0]];
         S_ACC: raw_bit = aa_q[cnt_q[4:0]];
         S_PDU: begin
            raw_bit = oct_q[cnt_q[2:0]];
            wht_en  = 1'b1;
         end
         S_CRC: begin
            raw_bit = crc_q[CRC_STATE_BIT_WIDTH-1];
            wht_en  = 1'b1;
         end
         default: raw_bit = 1'b0;
      endcase
      bit_out = raw_bit ^ (wht_en & wht_bit);
   end

   // Octet k+1 is addressed as soon as octet k is loaded, so RAM data has a full octet time to settle.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q    <= '0;
         aa_q     <= '0;
         crc_q    <= '0;
         len_q    <= '0;
         addr_q   <= '0;
         oct_q    <= '0;
         tx_end_q <= 1'b0;
      end else begin
         tx_end_q <= (state_q == S_CRC) && hs && last_bit;
         if (start) begin
            aa_q   <= unique_bit_sequence;
            crc_q  <= crc_state_init_bit;
            len_q  <= len_sat;
            addr_q <= '0;
            cnt_q  <= '0;
         end else if (hs) begin
            cnt_q <= last_bit ? 9'd0 : cnt_q + 9'd1;
            if (state_q == S_PDU)
               crc_q <= {crc_q[CRC_STATE_BIT_WIDTH-2:0], 1'b0}
                        ^ ((crc_q[CRC_STATE_BIT_WIDTH-1] ^ raw_bit) ? CRC_POLY : '0);
            if (state_q == S_CRC)
               crc_q <= {crc_q[CRC_STATE_BIT_WIDTH-2:0], 1'b0};
            if ((state_q == S_ACC && last_bit) || (state_q == S_PDU && cnt_q[2:0] == 3'd7)) begin
               oct_q <= pdu_octet_mem_data;
               if (addr_q != oct_last) addr_q <= addr_q + 6'd1;
            end
            if (state_q == S_CRC && last_bit) addr_q <= '0;
         end
      end
   end

`ifdef BTLE_TX_WHITENING_EN
   logic [6:0] wht_q;

   always_ff @(posedge clk) begin
      if (rst)
         wht_q <= '0;
      else if (start)
         wht_q <= {channel_number[0], channel_number[1], channel_number[2],
                   channel_number[3], channel_number[4], channel_number[5], 1'b1};
      else if (hs && wht_en)
         wht_q <= {wht_q[5], wht_q[4], wht_q[3] ^ wht_q[6], wht_q[2], wht_q[1], wht_q[0], wht_q[6]};
   end

   assign wht_bit = wht_q[6];
`else
   logic ch_unused;
   assign ch_unused = ^channel_number;
   assign wht_bit   = 1'b0;
`endif
endmodule

// File: tb/tb_btle_tx_framer.sv
// Directed bench for btle_tx_framer: reset, air-bit content, backpressure, saturation, busy start and mid-packet reset.
module tb_btle_tx_framer;
   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] unique_bit_sequence;
   logic [5:0]  channel_number;
   logic [23:0] crc_state_init_bit;
   logic [6:0]  payload_length;
   logic        tx_start;
   logic [5:0]  pdu_octet_mem_addr;
   logic [7:0]  pdu_octet_mem_data;
   logic        bit_out, bit_valid, bit_ready, tx_busy, tx_end;

`ifdef BTLE_TX_WHITENING_EN
   localparam logic WHT = 1'b1;
`else
   localparam logic WHT = 1'b0;
`endif

   btle_tx_framer dut (
      .clk                 (clk),
      .rst                 (rst),
      .unique_bit_sequence (unique_bit_sequence),
      .channel_number      (channel_number),
      .crc_state_init_bit  (crc_state_init_bit),
      .payload_length      (payload_length),
      .tx_start            (tx_start),
      .pdu_octet_mem_addr  (pdu_octet_mem_addr),
      .pdu_octet_mem_data  (pdu_octet_mem_data),
      .bit_out             (bit_out),
      .bit_valid           (bit_valid),
      .bit_ready           (bit_ready),
      .tx_busy             (tx_busy),
      .tx_end              (tx_end)
   );

   always #5 clk = ~clk;

   logic [7:0] mem [0:63];
   always @(posedge clk) pdu_octet_mem_data <= mem[pdu_octet_mem_addr];

   int   n_chk = 0, n_pass = 0, n_fail = 0;
   logic got [0:1023];
   logic exp_bits [0:1023];
   logic wseq [0:1023];
   int   exp_n, nbits, max_addr;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_chk++;
      assert (obs === expv) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   // Reference air-bit sequence built straight from the packet format.
   task automatic build_exp(input logic [31:0] aa, input logic [5:0] ch, input logic [23:0] init, input int L);
      logic [23:0] c;
      logic [6:0]  s;
      logic        d, fb, w;
      c = init;
      s = {ch[0], ch[1], ch[2], ch[3], ch[4], ch[5], 1'b1};
      exp_n = 0;
      for (int i = 0; i < 8; i++) begin
         exp_bits[exp_n] = (i % 2 == 1) ? ~aa[0] : aa[0];
         wseq[exp_n] = 1'b0; exp_n++;
      end
      for (int i = 0; i < 32; i++) begin
         exp_bits[exp_n] = aa[i];
         wseq[exp_n] = 1'b0; exp_n++;
      end
      for (int o = 0; o < L + 2; o++) begin
         for (int b = 0; b < 8; b++) begin
            d  = mem[o][b];
            fb = c[23] ^ d;
            c  = {c[22:0], 1'b0} ^ (fb ? 24'h00065B : 24'h0);
            w  = WHT & s[6];
            s  = {s[5], s[4], s[3] ^ s[6], s[2], s[1], s[0], s[6]};
            exp_bits[exp_n] = d ^ w;
            wseq[exp_n] = w; exp_n++;
         end
      end
      for (int i = 23; i >= 0; i--) begin
         w = WHT & s[6];
         s = {s[5], s[4], s[3] ^ s[6], s[2], s[1], s[0], s[6]};
         exp_bits[exp_n] = c[i] ^ w;
         wseq[exp_n] = w; exp_n++;
      end
   endtask

   // Starts at a negedge, returns at the negedge where tx_end is high (or on budget expiry).
   task automatic run_packet(input string tag, input logic [31:0] aa, input logic [5:0] ch,
                             input logic [23:0] init, input logic [6:0] plen,
                             input int pct_low, input int busy_at);
      int   nend, nunst, nmis;
      logic done, stall_prev, bit_prev, rdy;
      nend = 0; nunst = 0; nmis = 0;
      done = 1'b0; stall_prev = 1'b0; bit_prev = 1'b0;
      build_exp(aa, ch, init, (plen > 7'd62) ? 62 : int'(plen));
      unique_bit_sequence = aa;
      channel_number      = ch;
      crc_state_init_bit  = init;
      payload_length      = plen;
      tx_start            = 1'b1;
      @(negedge clk);
      tx_start            = 1'b0;
      unique_bit_sequence = ~aa;
      channel_number      = ~ch;
      crc_state_init_bit  = ~init;
      payload_length      = plen ^ 7'h15;
      check({tag, " start valid"}, 32'(bit_valid), 32'd1);
      check({tag, " start busy"},  32'(tx_busy),   32'd1);
      check({tag, " start no end"}, 32'(tx_end),   32'd0);
      nbits = 0; max_addr = 0;
      for (int c = 0; c < 4000 && !done; c++) begin
         if (stall_prev && bit_out !== bit_prev) nunst++;
         if (tx_end === 1'b1) begin
            nend++;
            done = 1'b1;
         end else begin
            rdy       = (pct_low == 0) || (int'($urandom_range(99)) >= pct_low);
            bit_ready = rdy;
            tx_start  = (c == busy_at);
            if (bit_valid && rdy && nbits < 1024) begin
               got[nbits] = bit_out;
               nbits++;
            end
            if (int'(pdu_octet_mem_addr) > max_addr) max_addr = int'(pdu_octet_mem_addr);
            stall_prev = bit_valid && !rdy;
            bit_prev   = bit_out;
            @(negedge clk);
         end
      end
      tx_start = 1'b0;
      for (int i = 0; i < exp_n && i < nbits; i++)
         if (got[i] !== exp_bits[i]) nmis++;
      check({tag, " end seen"},     32'(done),      32'd1);
      check({tag, " end count"},    32'(nend),      32'd1);
      check({tag, " bit count"},    32'(nbits),     32'(exp_n));
      check({tag, " bit mismatch"}, 32'(nmis),      32'd0);
      check({tag, " stall hold"},   32'(nunst),     32'd0);
      check({tag, " end valid"},    32'(bit_valid), 32'd0);
      check({tag, " end busy"},     32'(tx_busy),   32'd0);
   endtask

   initial begin
      logic [15:0] v16;
      logic [23:0] v24;
      logic [2:0]  v3;
      int          nend_rst;

      rst = 1'b1; tx_start = 1'b0; bit_ready = 1'b0;
      unique_bit_sequence = '0; channel_number = '0; crc_state_init_bit = '0; payload_length = '0;
      for (int i = 0; i < 64; i++) mem[i] = 8'h00;
      repeat (3) @(negedge clk);
      check("rst bit_valid", 32'(bit_valid), 32'd0);
      check("rst tx_busy",   32'(tx_busy),   32'd0);
      check("rst tx_end",    32'(tx_end),    32'd0);
      check("rst bit_out",   32'(bit_out),   32'd0);
      check("rst addr",      32'(pdu_octet_mem_addr), 32'd0);
      rst = 1'b0;
      bit_ready = 1'b1;
      @(negedge clk);

      // L=0, zero RAM, channel 37, CRC init 1: after 16 zero bits the CRC is 0x010000.
      run_packet("A", 32'h8E89BED6, 6'd37, 24'h000001, 7'd0, 0, -1);
      for (int i = 0; i < 16; i++) v16[i] = got[i];
      check("A first16", 32'(v16), 32'h0000D6AA);
      v3 = {got[42], got[41], got[40]};
      check("A pdu wht3", 32'(v3), WHT ? 32'd5 : 32'd0);
      for (int i = 0; i < 24; i++) v24[23 - i] = got[56 + i] ^ wseq[56 + i];
      check("A crc raw", 32'(v24), 32'h010000);

      // Back-to-back start, random payload, start pulse while busy.
      for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
      run_packet("B", 32'h8E89BED6, 6'd12, 24'h555555, 7'd37, 0, 100);
      check("B max addr", 32'(max_addr), 32'd38);

      @(negedge clk);
      run_packet("C", 32'h8E89BED6, 6'd12, 24'h555555, 7'd37, 30, -1);

      @(negedge clk);
      run_packet("D", 32'h12345671, 6'd5, 24'hA5C3F0, 7'd100, 0, -1);
      check("D max addr", 32'(max_addr), 32'd63);

      // Abort in the PDU phase.
      @(negedge clk);
      unique_bit_sequence = 32'h8E89BED6; channel_number = 6'd9;
      crc_state_init_bit = 24'h555555; payload_length = 7'd10;
      tx_start = 1'b1;
      @(negedge clk);
      tx_start = 1'b0;
      bit_ready = 1'b1;
      repeat (60) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("mid rst bit_valid", 32'(bit_valid), 32'd0);
      check("mid rst tx_busy",   32'(tx_busy),   32'd0);
      check("mid rst tx_end",    32'(tx_end),    32'd0);
      check("mid rst bit_out",   32'(bit_out),   32'd0);
      check("mid rst addr",      32'(pdu_octet_mem_addr), 32'd0);
      rst = 1'b0;
      nend_rst = 0;
      repeat (6) begin
         @(negedge clk);
         if (tx_end === 1'b1) nend_rst++;
      end
      check("mid rst no end", 32'(nend_rst), 32'd0);

      run_packet("F", 32'hC0FFEE01, 6'd37, 24'h555555, 7'd0, 0, -1);
      @(negedge clk);
      check("F end drop", 32'(tx_end), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
